// File: rtl/expr_pkg.sv
// Shared encodings for the expression evaluator: FSM states, character
// constants and character classes.
package expr_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_NUM  = 3'd1;
   localparam logic [2:0] ST_OP   = 3'd2;
   localparam logic [2:0] ST_ERR  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      NUM  = ST_NUM,
      OP   = ST_OP,
      ERR  = ST_ERR,
      DONE = ST_DONE
   } state_e;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;
   localparam logic [7:0] CH_EQ   = 8'h3D;

   typedef enum logic [2:0] {
      DIGIT = 3'd0,
      PLUS  = 3'd1,
      STAR  = 3'd2,
      EQ    = 3'd3,
      OTHER = 3'd4
   } cls_e;

endpackage

// File: rtl/expr_eval_char_class.sv
// Combinational character classifier: maps one ASCII byte to a token class
// and, for digits, its numeric value.
module char_class
   import expr_pkg::*;
(
   input  logic [7:0] ch,
   output logic [2:0] cls,
   output logic [3:0] digit
);

   // Classify the incoming character
   always_comb begin
      cls   = OTHER;
      digit = 4'd0;
      if ((ch >= CH_0) && (ch <= CH_9)) begin
         cls   = DIGIT;
         digit = ch[3:0];
      end else if (ch == CH_PLUS) begin
         cls = PLUS;
      end else if (ch == CH_STAR) begin
         cls = STAR;
      end else if (ch == CH_EQ) begin
         cls = EQ;
      end else begin
         cls = OTHER;
      end
   end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for digit (op digit)* '=' with '*' binding tighter
// than '+'; the registered result is handed off with a valid/ready pair.
module expr_eval
   import expr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             error,
   output logic             overflow
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [WIDTH-1:0]   term_q, term_d;
   logic               pend_op_q, pend_op_d;
   logic               ovf_q, ovf_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               error_q, error_d;
   logic               overflow_q, overflow_d;

   logic [2:0]         cls_s;
   logic [3:0]         digit_s;
   logic [WIDTH+3:0]   prod_s;
   logic [WIDTH:0]     add_s;
   logic               go_err_s;
   logic               go_ok_s;

   char_class u_cc (
      .ch    (in_data),
      .cls   (cls_s),
      .digit (digit_s)
   );

   // Both the mid-expression accumulate and the final '=' use sum+term
   assign prod_s = {4'b0000, term_q} * {{WIDTH{1'b0}}, digit_s};
   assign add_s  = {1'b0, sum_q} + {1'b0, term_q};

   assign in_ready  = (state_q != DONE);
   assign out_valid = valid_q;
   assign result    = result_q;
   assign error     = error_q;
   assign overflow  = overflow_q;

   // Next-state, accumulator and output-register computation
   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      term_d     = term_q;
      pend_op_d  = pend_op_q;
      ovf_d      = ovf_q;
      valid_d    = valid_q;
      result_d   = result_q;
      error_d    = error_q;
      overflow_d = overflow_q;
      go_err_s   = 1'b0;
      go_ok_s    = 1'b0;

      if (state_q == DONE) begin
         if (out_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
         end else begin
            state_d = DONE;
         end
      end else if (in_valid) begin
         case (state_q)
            IDLE: begin
               if (cls_s == DIGIT) begin
                  sum_d   = {WIDTH{1'b0}};
                  term_d  = {{(WIDTH-4){1'b0}}, digit_s};
                  ovf_d   = 1'b0;
                  state_d = NUM;
               end else if (cls_s == EQ) begin
                  go_err_s = 1'b1;
               end else begin
                  state_d = ERR;
               end
            end
            NUM: begin
               case (cls_s)
                  PLUS: begin
                     pend_op_d = 1'b0;
                     state_d   = OP;
                  end
                  STAR: begin
                     pend_op_d = 1'b1;
                     state_d   = OP;
                  end
                  EQ:      go_ok_s = 1'b1;
                  default: state_d = ERR;
               endcase
            end
            OP: begin
               if (cls_s == DIGIT) begin
                  if (pend_op_q) begin
                     term_d = prod_s[WIDTH-1:0];
                     ovf_d  = ovf_q | (|prod_s[WIDTH+3:WIDTH]);
                  end else begin
                     sum_d  = add_s[WIDTH-1:0];
                     term_d = {{(WIDTH-4){1'b0}}, digit_s};
                     ovf_d  = ovf_q | add_s[WIDTH];
                  end
                  state_d = NUM;
               end else if (cls_s == EQ) begin
                  go_err_s = 1'b1;
               end else begin
                  state_d = ERR;
               end
            end
            ERR: begin
               if (cls_s == EQ) begin
                  go_err_s = 1'b1;
               end else begin
                  state_d = ERR;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end

      if (go_err_s) begin
         state_d    = DONE;
         valid_d    = 1'b1;
         result_d   = {WIDTH{1'b0}};
         error_d    = 1'b1;
         overflow_d = 1'b0;
      end else if (go_ok_s) begin
         state_d    = DONE;
         valid_d    = 1'b1;
         result_d   = add_s[WIDTH-1:0];
         error_d    = 1'b0;
         overflow_d = ovf_q | add_s[WIDTH];
      end else begin
         valid_d = valid_d;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= IDLE;
         sum_q      <= {WIDTH{1'b0}};
         term_q     <= {WIDTH{1'b0}};
         pend_op_q  <= 1'b0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         result_q   <= {WIDTH{1'b0}};
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         term_q     <= term_d;
         pend_op_q  <= pend_op_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         error_q    <= error_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
